// File: rtl/speicher_steuerung.sv
// speicher_steuerung: memory access controller between the CPU load/store
// path and a single-port synchronous RAM with a 1-cycle registered read.
// One request is handled at a time. An address with bit IO_ADDR_BIT set goes
// to the memory-mapped IO output register or input port instead of the RAM.
//
// Handshake: a request is accepted on a rising edge where Bereit=1 and
// Anfrage=1. While Bereit=0, Anfrage is ignored and not queued, so the CPU
// keeps it asserted until acceptance. Every accepted request gets exactly one
// single-cycle Fertig pulse. The Fertig cycle is always an idle cycle, so a
// new request can be accepted in it.
module speicher_steuerung #(
    parameter int WORDSIZE    = 32,
    parameter int WORDS       = 256,
    parameter int IO_ADDR_BIT = 31
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Anfrage,
    input  logic                      Schreiben,
    input  logic [31:0]               Adresse,
    input  logic [WORDSIZE-1:0]       DatenRein,
    output logic                      Bereit,
    output logic                      Fertig,
    output logic [WORDSIZE-1:0]       DatenRaus,
    output logic                      RamSchreibenAn,
    output logic [$clog2(WORDS)-1:0]  RamAdresse,
    output logic [WORDSIZE-1:0]       RamDatenRein,
    input  logic [WORDSIZE-1:0]       RamDatenRaus,
    input  logic [WORDSIZE-1:0]       IoEingabe,
    output logic [WORDSIZE-1:0]       IoAusgabe,
    output logic [1:0]                ZustandDbg
);

    localparam int AW = $clog2(WORDS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SCHREIBEN = 2'd1,
        LESEN     = 2'd2,
        WARTEN    = 2'd3
    } zustand_t;

    zustand_t              zustand_q, zustand_d;
    logic [AW-1:0]         adresse_q;
    logic [WORDSIZE-1:0]   daten_q;
    logic [WORDSIZE-1:0]   datenraus_q;
    logic [WORDSIZE-1:0]   io_q;
    logic                  fertig_q;

    logic                  annahme;
    logic                  ist_io;
    logic                  unused_adresse;

    // The address bits between AW and IO_ADDR_BIT are ignored on purpose:
    // the RAM aliases modulo WORDS.
    assign unused_adresse = ^Adresse;

    assign ist_io  = Adresse[IO_ADDR_BIT];
    assign annahme = (zustand_q == IDLE) && Anfrage && !Reset;

    // State register; reset drops any request in flight.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            zustand_q <= IDLE;
        end else begin
            zustand_q <= zustand_d;
        end
    end

    // Next state: IO accesses finish without leaving IDLE.
    // RAM writes take one cycle; RAM reads take two cycles.
    always_comb begin
        zustand_d = zustand_q;
        case (zustand_q)
            IDLE: begin
                if (Anfrage && !ist_io) begin
                    zustand_d = Schreiben ? SCHREIBEN : LESEN;
                end
            end
            SCHREIBEN: zustand_d = IDLE;
            LESEN:     zustand_d = WARTEN;
            WARTEN:    zustand_d = IDLE;
            default:   zustand_d = IDLE;
        endcase
    end

    // Request latch, IO register, read result and completion pulse.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            adresse_q   <= '0;
            daten_q     <= '0;
            datenraus_q <= '0;
            io_q        <= '0;
            fertig_q    <= 1'b0;
        end else begin
            fertig_q <= 1'b0;
            if (annahme) begin
                adresse_q <= Adresse[AW-1:0];
                daten_q   <= DatenRein;
                if (ist_io) begin
                    fertig_q <= 1'b1;
                    if (Schreiben) begin
                        io_q <= DatenRein;
                    end else begin
                        datenraus_q <= IoEingabe;
                    end
                end
            end
            if (zustand_q == SCHREIBEN) begin
                fertig_q <= 1'b1;
            end
            // The RAM captured the address at the end of LESEN, so its
            // registered output is valid throughout WARTEN.
            if (zustand_q == WARTEN) begin
                datenraus_q <= RamDatenRaus;
                fertig_q    <= 1'b1;
            end
        end
    end

    assign Bereit         = (zustand_q == IDLE) && !Reset;
    assign RamSchreibenAn = (zustand_q == SCHREIBEN) && !Reset;
    assign RamAdresse     = adresse_q;
    assign RamDatenRein   = daten_q;
    assign Fertig         = fertig_q;
    assign DatenRaus      = datenraus_q;
    assign IoAusgabe      = io_q;
    assign ZustandDbg     = zustand_q;

endmodule

// File: tb/tb_speicher_steuerung.sv
// Bench for speicher_steuerung. It includes a behavioural single-port RAM
// with a registered read, directed requests, and a queue-based scoreboard
// that checks each Fertig pulse.
module tb_speicher_steuerung;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          anfrage;
    logic          schreiben;
    logic [31:0]   adresse;
    logic [W-1:0]  daten_rein;
    logic          bereit;
    logic          fertig;
    logic [W-1:0]  daten_raus;
    logic          ram_we;
    logic [7:0]    ram_adr;
    logic [W-1:0]  ram_din;
    logic [W-1:0]  ram_dout;
    logic [W-1:0]  io_ein;
    logic [W-1:0]  io_aus;
    logic [1:0]    zustand_dbg;

    speicher_steuerung #(.WORDSIZE(32), .WORDS(256), .IO_ADDR_BIT(31)) dut (
        .Clock          (clk),
        .Reset          (rst),
        .Anfrage        (anfrage),
        .Schreiben      (schreiben),
        .Adresse        (adresse),
        .DatenRein      (daten_rein),
        .Bereit         (bereit),
        .Fertig         (fertig),
        .DatenRaus      (daten_raus),
        .RamSchreibenAn (ram_we),
        .RamAdresse     (ram_adr),
        .RamDatenRein   (ram_din),
        .RamDatenRaus   (ram_dout),
        .IoEingabe      (io_ein),
        .IoAusgabe      (io_aus),
        .ZustandDbg     (zustand_dbg)
    );

    // ---------------- clock / reset / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- RAM model: write when enabled, else registered read
    logic [W-1:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        ram_dout = '0;
    end
    always @(posedge clk) begin
        if (ram_we) mem[ram_adr] <= ram_din;
        else        ram_dout     <= mem[ram_adr];
    end

    int we_cnt = 0;
    always @(negedge clk) if (ram_we === 1'b1) we_cnt <= we_cnt + 1;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    bit           rd_q[$];
    int           cyc_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every Fertig pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (fertig === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_fertig: got Fertig=1 expected no pending request (cycle %0d)", cyc);
            end else begin
                logic [W-1:0] e;
                bit           r;
                int           c;
                e = exp_q.pop_front();
                r = rd_q.pop_front();
                c = cyc_q.pop_front();
                chk("fertig_cycle", cyc, c);
                chk("bereit_in_fertig", {31'd0, bereit}, 32'd1);
                if (r) chk("daten_raus", daten_raus, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Issue one request; lat = expected edges from acceptance to Fertig,
    // lat = 0 means the request will be killed by reset (no expectation).
    // hold = 1 leaves Anfrage asserted for a directly following request.
    task automatic req(input bit wr, input logic [31:0] a, input logic [W-1:0] d,
                       input logic [W-1:0] expv, input int lat, input bit hold);
        int budget;
        @(negedge clk);
        anfrage    = 1'b1;
        schreiben  = wr;
        adresse    = a;
        daten_rein = d;
        budget = 0;
        while (bereit !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (bereit !== 1'b1) begin
            chk("accept_timeout", {31'd0, bereit}, 32'd1);
            anfrage = 1'b0;
            return;
        end
        if (lat > 0) begin
            exp_q.push_back(expv);
            rd_q.push_back(!wr);
            cyc_q.push_back(cyc + lat);
        end
        @(posedge clk);
        #1;
        if (!hold) anfrage = 1'b0;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || bereit !== 1'b1) && budget < 30) begin
            @(negedge clk);
            budget++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    int we0;
    initial begin
        rst = 1'b1; anfrage = 1'b0; schreiben = 1'b0;
        adresse = '0; daten_rein = '0; io_ein = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_fertig",    {31'd0, fertig}, 32'd0);
        chk("rst_datenraus", daten_raus, 32'd0);
        chk("rst_ioausgabe", io_aus, 32'd0);
        chk("rst_ram_we",    {31'd0, ram_we}, 32'd0);
        chk("rst_bereit_lo", {31'd0, bereit}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("bereit_after_rst", {31'd0, bereit}, 32'd1);

        // RAM write then read
        we0 = we_cnt;
        req(1, 32'd5, 32'hDEADBEEF, '0, 2, 0);
        wait_idle();
        chk("ram_we_once", we_cnt - we0, 32'd1);
        req(0, 32'd5, '0, 32'hDEADBEEF, 3, 0);
        wait_idle();

        // IO write and read
        we0 = we_cnt;
        req(1, 32'h8000_0000, 32'h0000_0012, '0, 1, 0);
        wait_idle();
        chk("io_ausgabe", io_aus, 32'h0000_0012);
        chk("io_no_ram_we", we_cnt - we0, 32'd0);
        io_ein = 32'hA5A5A5A5;
        req(0, 32'h8000_0000, '0, 32'hA5A5A5A5, 1, 0);
        wait_idle();
        chk("io_ausgabe_kept", io_aus, 32'h0000_0012);

        // Aliasing modulo 256
        req(1, 32'h0000_0105, 32'h11, '0, 2, 0);
        req(0, 32'h0000_0005, '0, 32'h11, 3, 0);
        wait_idle();

        // Back-to-back reads with Anfrage held
        req(1, 32'd3, 32'h33, '0, 2, 0);
        req(1, 32'd4, 32'h44, '0, 2, 0);
        wait_idle();
        req(0, 32'd3, '0, 32'h33, 3, 1);
        req(0, 32'd4, '0, 32'h44, 3, 0);
        wait_idle();
        chk("datenraus_hold", daten_raus, 32'h44);

        // Reset during SCHREIBEN: write suppressed, no Fertig
        req(1, 32'd9, 32'h55, '0, 2, 0);
        wait_idle();
        we0 = we_cnt;
        req(1, 32'd9, 32'h77, '0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_datenraus", daten_raus, 32'd0);
        chk("rst_mid_ioausgabe", io_aus, 32'd0);
        chk("rst_mid_no_we", we_cnt - we0, 32'd0);
        repeat (3) @(negedge clk);
        req(0, 32'd9, '0, 32'h55, 3, 0);
        wait_idle();

        // Reset during WARTEN: no Fertig, DatenRaus cleared
        req(0, 32'd5, '0, '0, 0, 0);
        @(posedge clk);
        #1;
        chk("in_warten", {30'd0, zustand_dbg}, 32'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_warten_datenraus", daten_raus, 32'd0);
        chk("rst_warten_fertig", {31'd0, fertig}, 32'd0);
        repeat (3) @(negedge clk);
        req(0, 32'd4, '0, 32'h44, 3, 0);
        wait_idle();

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
